// File: rtl/gmii_rx_guard_if.sv
// GMII receive byte stream in, conditioned byte stream out.
// master drives the Rx pins and observes the output; slave is the guard itself.
interface gmii_rx_guard_if;
    logic [7:0] rxd;
    logic       rx_dv;
    logic       rx_er;
    logic [7:0] d_out;
    logic       strobe_out;
    logic       frame_end;
    logic       frame_bad;

    modport master (
        output rxd, rx_dv, rx_er,
        input  d_out, strobe_out, frame_end, frame_bad
    );

    modport slave (
        input  rxd, rx_dv, rx_er,
        output d_out, strobe_out, frame_end, frame_bad
    );
endinterface

// File: rtl/gmii_rx_guard.sv
// Purpose: GMII Rx conditioning; poisons (inverts last byte of) errored or over-length frames, keeps stats.
// Latency: byte sampled at edge n is on d_out after edge n+2. Backpressure: none, the GMII stream cannot stall.
module gmii_rx_guard #(
    parameter int max_len = 1530,
    parameter int cnt_w   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    gmii_rx_guard_if.slave    bus,
    input  logic              clear,
    output logic [cnt_w-1:0]  frame_cnt,
    output logic [cnt_w-1:0]  err_cnt,
    output logic [cnt_w-1:0]  trunc_cnt,
    output logic [cnt_w-1:0]  fc_cnt
);
    typedef enum logic [1:0] {RESYNC, IDLE, FRAME, DROP} state_t;

    localparam logic [15:0]      LP_MAX_LEN = 16'(max_len);
    localparam logic [cnt_w-1:0] LP_ONE     = 1;

    state_t      r_state, w_state_nxt;
    logic [15:0] r_len, w_len_nxt;
    logic        r_poison, w_poison_nxt;
    logic        w_accept, w_hit, w_fc;

    logic       r_s1_vld, r_s1_poison, r_s1_trunc;
    logic [7:0] r_s1_dat;
    logic       r_s2_vld, r_s2_last, r_s2_poison, r_s2_trunc;
    logic [7:0] r_s2_dat;

    logic [7:0] r_d_out;
    logic       r_strobe, r_end, r_bad, r_end_poison, r_end_trunc;
    logic       r_fc_prev, r_fc_evt;

    assign w_fc = bus.rx_er & ~bus.rx_dv & (bus.rxd == 8'h0E);

    always_comb begin
        w_state_nxt  = r_state;
        w_len_nxt    = r_len;
        w_poison_nxt = r_poison;
        w_accept     = 1'b0;
        w_hit        = 1'b0;
        case (r_state)
            RESYNC: if (!bus.rx_dv) w_state_nxt = IDLE;
            IDLE: begin
                if (bus.rx_dv) begin
                    w_accept     = 1'b1;
                    w_len_nxt    = 16'd1;
                    w_poison_nxt = bus.rx_er;
                    w_state_nxt  = FRAME;
                end
            end
            FRAME: begin
                if (bus.rx_dv) begin
                    w_accept     = 1'b1;
                    w_len_nxt    = (r_len == 16'hFFFF) ? r_len : r_len + 16'd1;
                    w_poison_nxt = r_poison | bus.rx_er;
                    if (w_len_nxt >= LP_MAX_LEN) begin
                        w_hit       = 1'b1;
                        w_state_nxt = DROP;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            DROP: if (!bus.rx_dv) w_state_nxt = IDLE;
            default: w_state_nxt = RESYNC;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= RESYNC;
            r_len       <= 16'd0;
            r_poison    <= 1'b0;
            r_s1_vld    <= 1'b0;
            r_s1_dat    <= 8'h00;
            r_s1_poison <= 1'b0;
            r_s1_trunc  <= 1'b0;
            r_s2_vld    <= 1'b0;
            r_s2_last   <= 1'b0;
            r_s2_dat    <= 8'h00;
            r_s2_poison <= 1'b0;
            r_s2_trunc  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_len       <= w_len_nxt;
            r_poison    <= w_poison_nxt;
            // Each staged byte carries the poison accumulated up to and including itself.
            r_s1_vld    <= w_accept;
            r_s1_dat    <= bus.rxd;
            r_s1_poison <= w_poison_nxt;
            r_s1_trunc  <= w_hit;
            // A staged byte is last if it hit max_len or the stream dropped dv behind it.
            r_s2_vld    <= r_s1_vld;
            r_s2_last   <= r_s1_vld & (r_s1_trunc | ~bus.rx_dv);
            r_s2_dat    <= r_s1_dat;
            r_s2_poison <= r_s1_poison;
            r_s2_trunc  <= r_s1_trunc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d_out      <= 8'h00;
            r_strobe     <= 1'b0;
            r_end        <= 1'b0;
            r_bad        <= 1'b0;
            r_end_poison <= 1'b0;
            r_end_trunc  <= 1'b0;
        end else begin
            r_strobe     <= r_s2_vld;
            r_end        <= r_s2_vld & r_s2_last;
            r_bad        <= r_s2_vld & r_s2_last & (r_s2_poison | r_s2_trunc);
            r_end_poison <= r_s2_vld & r_s2_last & r_s2_poison;
            r_end_trunc  <= r_s2_vld & r_s2_last & r_s2_trunc;
            if (!r_s2_vld)
                r_d_out <= 8'h00;
            else if (r_s2_last && (r_s2_poison || r_s2_trunc))
                r_d_out <= ~r_s2_dat;
            else
                r_d_out <= r_s2_dat;
        end
    end

    assign bus.d_out      = r_d_out;
    assign bus.strobe_out = r_strobe;
    assign bus.frame_end  = r_end;
    assign bus.frame_bad  = r_bad;

    function automatic logic [cnt_w-1:0] f_bump(input logic [cnt_w-1:0] c, input logic e);
        return (e && (c != '1)) ? c + LP_ONE : c;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fc_prev <= 1'b0;
            r_fc_evt  <= 1'b0;
            frame_cnt <= '0;
            err_cnt   <= '0;
            trunc_cnt <= '0;
            fc_cnt    <= '0;
        end else begin
            r_fc_prev <= w_fc;
            r_fc_evt  <= w_fc & ~r_fc_prev;
            if (clear) begin
                frame_cnt <= '0;
                err_cnt   <= '0;
                trunc_cnt <= '0;
                fc_cnt    <= '0;
            end else begin
                frame_cnt <= f_bump(frame_cnt, r_end);
                err_cnt   <= f_bump(err_cnt, r_end_poison);
                trunc_cnt <= f_bump(trunc_cnt, r_end_trunc);
                fc_cnt    <= f_bump(fc_cnt, r_fc_evt);
            end
        end
    end
endmodule

// File: tb/tb_gmii_rx_guard.sv
// Directed bench: dut_a uses default max_len/cnt_w, dut_b uses max_len=16, cnt_w=4; both see the same Rx pins.
module tb_gmii_rx_guard;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rxd = 8'h00;
    logic       rx_dv = 1'b0;
    logic       rx_er = 1'b0;
    logic       clear = 1'b0;
    int         cyc = 0;
    int         n_chk = 0;
    int         n_fail = 0;

    logic [15:0] a_frame_cnt, a_err_cnt, a_trunc_cnt, a_fc_cnt;
    logic [3:0]  b_frame_cnt, b_err_cnt, b_trunc_cnt, b_fc_cnt;

    typedef struct packed {
        logic [7:0]  dat;
        logic        fend;
        logic        fbad;
        logic [31:0] cyc;
    } mon_t;

    mon_t       mon_a[$];
    mon_t       mon_b[$];
    logic [7:0] frm[64];

    gmii_rx_guard_if ia();
    gmii_rx_guard_if ib();

    assign ia.rxd = rxd;  assign ia.rx_dv = rx_dv;  assign ia.rx_er = rx_er;
    assign ib.rxd = rxd;  assign ib.rx_dv = rx_dv;  assign ib.rx_er = rx_er;

    gmii_rx_guard #(.max_len(1530), .cnt_w(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ia), .clear(clear),
        .frame_cnt(a_frame_cnt), .err_cnt(a_err_cnt), .trunc_cnt(a_trunc_cnt), .fc_cnt(a_fc_cnt)
    );

    gmii_rx_guard #(.max_len(16), .cnt_w(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ib), .clear(clear),
        .frame_cnt(b_frame_cnt), .err_cnt(b_err_cnt), .trunc_cnt(b_trunc_cnt), .fc_cnt(b_fc_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ia.strobe_out) mon_a.push_back('{ia.d_out, ia.frame_end, ia.frame_bad, 32'(cyc)});
        if (ib.strobe_out) mon_b.push_back('{ib.d_out, ib.frame_end, ib.frame_bad, 32'(cyc)});
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input logic dv, input logic er, input logic [7:0] d);
        rx_dv = dv; rx_er = er; rxd = d;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; rx_dv = 1'b0; rx_er = 1'b0; rxd = 8'h00; clear = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) tick(1'b0, 1'b0, 8'h00);
        mon_a.delete(); mon_b.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rx_dv = 1'b1; rxd = 8'hFF;
        @(negedge clk);
        n_chk++; if ({ia.d_out, ia.strobe_out, ia.frame_end, ia.frame_bad} !== 11'h0) begin
            n_fail++; $display("FAIL reset_outputs: got %h want 000", {ia.d_out, ia.strobe_out, ia.frame_end, ia.frame_bad});
        end
        n_chk++; if ({a_frame_cnt, a_err_cnt, a_trunc_cnt, a_fc_cnt} !== 64'h0) begin
            n_fail++; $display("FAIL reset_cnt_a: got %h want 0", {a_frame_cnt, a_err_cnt, a_trunc_cnt, a_fc_cnt});
        end
        n_chk++; if ({b_frame_cnt, b_err_cnt, b_trunc_cnt, b_fc_cnt} !== 16'h0) begin
            n_fail++; $display("FAIL reset_cnt_b: got %h want 0", {b_frame_cnt, b_err_cnt, b_trunc_cnt, b_fc_cnt});
        end
        do_reset();
    endtask

    task automatic send_frame64(input int er_idx);
        int   s0;
        mon_t exp;
        s0 = 0;
        for (int i = 0; i < 64; i++) begin
            tick(1'b1, (i == er_idx), frm[i]);
            if (i == 0) s0 = cyc;
        end
        repeat (6) tick(1'b0, 1'b0, 8'h00);
        n_chk++; if (mon_a.size() !== 64) begin
            n_fail++; $display("FAIL frame64_count(er=%0d): got %0d strobes want 64", er_idx, mon_a.size());
        end
        for (int i = 0; i < 64 && i < mon_a.size(); i++) begin
            exp = '{(i == 63 && er_idx >= 0) ? ~frm[i] : frm[i], (i == 63), (i == 63 && er_idx >= 0), 32'(s0 + 2 + i)};
            n_chk++; if (mon_a[i] !== exp) begin
                n_fail++; $display("FAIL frame64_byte%0d(er=%0d): got %h want %h", i + 1, er_idx, mon_a[i], exp);
            end
        end
        n_chk++; if (a_frame_cnt !== 16'd1) begin
            n_fail++; $display("FAIL frame64_frame_cnt: got %0d want 1", a_frame_cnt);
        end
        n_chk++; if (a_err_cnt !== ((er_idx >= 0) ? 16'd1 : 16'd0)) begin
            n_fail++; $display("FAIL frame64_err_cnt(er=%0d): got %0d", er_idx, a_err_cnt);
        end
    endtask

    task automatic test_good_frame();
        do_reset();
        send_frame64(-1);
    endtask

    task automatic test_rx_er();
        do_reset();
        send_frame64(19);
        n_chk++; if (a_trunc_cnt !== 16'd0) begin
            n_fail++; $display("FAIL rx_er_trunc_cnt: got %0d want 0", a_trunc_cnt);
        end
    endtask

    task automatic test_truncate();
        int   s0;
        mon_t exp;
        do_reset();
        s0 = 0;
        for (int k = 1; k <= 40; k++) begin
            tick(1'b1, 1'b0, 8'(k));
            if (k == 1) s0 = cyc;
        end
        repeat (4) tick(1'b0, 1'b0, 8'h00);
        n_chk++; if (mon_b.size() !== 16) begin
            n_fail++; $display("FAIL trunc_count: got %0d strobes want 16", mon_b.size());
        end
        for (int k = 1; k <= 16 && k <= mon_b.size(); k++) begin
            exp = '{(k == 16) ? 8'hEF : 8'(k), (k == 16), (k == 16), 32'(s0 + 1 + k)};
            n_chk++; if (mon_b[k-1] !== exp) begin
                n_fail++; $display("FAIL trunc_byte%0d: got %h want %h", k, mon_b[k-1], exp);
            end
        end
        n_chk++; if ({b_frame_cnt, b_err_cnt, b_trunc_cnt} !== {4'd1, 4'd0, 4'd1}) begin
            n_fail++; $display("FAIL trunc_cnts: got %h want 101", {b_frame_cnt, b_err_cnt, b_trunc_cnt});
        end
        mon_b.delete();
        for (int k = 1; k <= 5; k++) tick(1'b1, 1'b0, 8'(8'hA0 + k));
        repeat (4) tick(1'b0, 1'b0, 8'h00);
        n_chk++; if (mon_b.size() !== 5) begin
            n_fail++; $display("FAIL trunc_next_count: got %0d want 5", mon_b.size());
        end
        for (int k = 1; k <= 5 && k <= mon_b.size(); k++) begin
            n_chk++; if ({mon_b[k-1].dat, mon_b[k-1].fend, mon_b[k-1].fbad} !== {8'(8'hA0 + k), (k == 5), 1'b0}) begin
                n_fail++; $display("FAIL trunc_next_byte%0d: got %h", k, mon_b[k-1]);
            end
        end
        n_chk++; if ({b_frame_cnt, b_trunc_cnt} !== {4'd2, 4'd1}) begin
            n_fail++; $display("FAIL trunc_next_cnts: got %h want 21", {b_frame_cnt, b_trunc_cnt});
        end
    endtask

    task automatic test_back_to_back();
        int   s0;
        mon_t exp[4];
        do_reset();
        tick(1'b1, 1'b0, 8'h11); s0 = cyc;
        tick(1'b1, 1'b0, 8'h22);
        tick(1'b1, 1'b0, 8'h33);
        tick(1'b0, 1'b0, 8'h00);
        tick(1'b1, 1'b0, 8'h44);
        repeat (5) tick(1'b0, 1'b0, 8'h00);
        exp[0] = '{8'h11, 1'b0, 1'b0, 32'(s0 + 2)};
        exp[1] = '{8'h22, 1'b0, 1'b0, 32'(s0 + 3)};
        exp[2] = '{8'h33, 1'b1, 1'b0, 32'(s0 + 4)};
        exp[3] = '{8'h44, 1'b1, 1'b0, 32'(s0 + 6)};
        n_chk++; if (mon_a.size() !== 4) begin
            n_fail++; $display("FAIL b2b_count: got %0d want 4", mon_a.size());
        end
        for (int i = 0; i < 4 && i < mon_a.size(); i++) begin
            n_chk++; if (mon_a[i] !== exp[i]) begin
                n_fail++; $display("FAIL b2b_entry%0d: got %h want %h", i, mon_a[i], exp[i]);
            end
        end
        n_chk++; if (a_frame_cnt !== 16'd2) begin
            n_fail++; $display("FAIL b2b_frame_cnt: got %0d want 2", a_frame_cnt);
        end
    endtask

    task automatic test_false_carrier();
        do_reset();
        repeat (3) tick(1'b0, 1'b1, 8'h0E);
        repeat (2) tick(1'b0, 1'b0, 8'h00);
        n_chk++; if (a_fc_cnt !== 16'd1) begin
            n_fail++; $display("FAIL fc_first_episode: got %0d want 1", a_fc_cnt);
        end
        tick(1'b0, 1'b1, 8'h0E);
        tick(1'b0, 1'b0, 8'h00);
        tick(1'b0, 1'b1, 8'h1F);
        repeat (3) tick(1'b0, 1'b0, 8'h00);
        n_chk++; if (a_fc_cnt !== 16'd2) begin
            n_fail++; $display("FAIL fc_total: got %0d want 2", a_fc_cnt);
        end
        n_chk++; if (mon_a.size() !== 0 || a_frame_cnt !== 16'd0) begin
            n_fail++; $display("FAIL fc_no_strobe: got %0d strobes, frame_cnt %0d, want 0/0", mon_a.size(), a_frame_cnt);
        end
    endtask

    task automatic test_resync();
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) tick(1'b1, 1'b0, 8'(8'h60 + k));
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) tick(1'b1, (k == 4), 8'(8'h70 + k));
        repeat (3) tick(1'b0, 1'b0, 8'h00);
        n_chk++; if (mon_a.size() !== 0 || a_frame_cnt !== 16'd0 || a_err_cnt !== 16'd0) begin
            n_fail++; $display("FAIL resync_ignored: got %0d strobes, frame_cnt %0d, err_cnt %0d, want 0", mon_a.size(), a_frame_cnt, a_err_cnt);
        end
        for (int k = 1; k <= 4; k++) tick(1'b1, 1'b0, 8'(8'h80 + k));
        repeat (4) tick(1'b0, 1'b0, 8'h00);
        n_chk++; if (mon_a.size() !== 4) begin
            n_fail++; $display("FAIL resync_next_count: got %0d want 4", mon_a.size());
        end
        if (mon_a.size() == 4) begin
            n_chk++; if ({mon_a[0].dat, mon_a[3].dat, mon_a[3].fend, mon_a[3].fbad} !== {8'h81, 8'h84, 1'b1, 1'b0}) begin
                n_fail++; $display("FAIL resync_next_bytes: got %h %h", mon_a[0], mon_a[3]);
            end
        end
        n_chk++; if (a_frame_cnt !== 16'd1) begin
            n_fail++; $display("FAIL resync_frame_cnt: got %0d want 1", a_frame_cnt);
        end
    endtask

    task automatic test_saturation();
        logic found;
        do_reset();
        for (int f = 0; f < 16; f++) begin
            tick(1'b1, 1'b1, 8'hC0);
            tick(1'b1, 1'b0, 8'hC1);
            repeat (2) tick(1'b0, 1'b0, 8'h00);
            if (f == 14) begin
                tick(1'b0, 1'b0, 8'h00);
                n_chk++; if (b_frame_cnt !== 4'd15) begin
                    n_fail++; $display("FAIL sat_reach: got %0d want 15", b_frame_cnt);
                end
            end
        end
        repeat (3) tick(1'b0, 1'b0, 8'h00);
        n_chk++; if ({b_frame_cnt, b_err_cnt} !== 8'hFF) begin
            n_fail++; $display("FAIL sat_hold: got %h want ff", {b_frame_cnt, b_err_cnt});
        end
        tick(1'b1, 1'b0, 8'hD0);
        tick(1'b1, 1'b0, 8'hD1);
        tick(1'b0, 1'b0, 8'h00);
        found = 1'b0;
        for (int w = 0; w < 10; w++) begin
            @(negedge clk);
            if (ib.frame_end) begin found = 1'b1; break; end
        end
        n_chk++; if (!found) begin
            n_fail++; $display("FAIL sat_frame_end_wait: got no frame_end within 10 cycles, want one");
        end
        clear = 1'b1;
        @(posedge clk); #1 clear = 1'b0;
        @(negedge clk);
        n_chk++; if ({b_frame_cnt, b_err_cnt} !== 8'h00) begin
            n_fail++; $display("FAIL sat_clear_priority: got %h want 00", {b_frame_cnt, b_err_cnt});
        end
        tick(1'b0, 1'b0, 8'h00);
        tick(1'b1, 1'b0, 8'hE0);
        repeat (4) tick(1'b0, 1'b0, 8'h00);
        n_chk++; if (b_frame_cnt !== 4'd1) begin
            n_fail++; $display("FAIL sat_after_clear: got %0d want 1", b_frame_cnt);
        end
    endtask

    initial begin
        for (int i = 0; i < 7; i++) frm[i] = 8'h55;
        frm[7] = 8'hD5;
        for (int i = 8; i < 63; i++) frm[i] = 8'(i * 7 + 3);
        frm[63] = 8'h5A;

        test_reset();
        test_good_frame();
        test_rx_er();
        test_truncate();
        test_back_to_back();
        test_false_carrier();
        test_resync();
        test_saturation();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/gmii_rx_guard.md
Name: gmii_rx_guard

Overview:
- Single-clock receive-side conditioning stage in the GMII receive clock domain.
- Sits between the IOB-latched GMII Rx pins (rxd/rx_dv/rx_er) and the Rx clock-crossing FIFO that feeds the abstract Ethernet layer.
- Enforces rx_er handling: any frame carrying rx_er, or exceeding the maximum length, leaves with its last byte inverted so the downstream CRC check always rejects it.
- Keeps saturating statistics counters for the local bus.

Parameters:
max_len, 1530, maximum forwarded bytes per frame including preamble/SFD (1522 + 8); range 2..65535
cnt_w, 16, width of each statistics counter

Ports:
clk  input  1  GMII Rx clock; all logic on rising edge
rst_n  input  1  asynchronous active-low reset
rxd  input  8  latched GMII receive data
rx_dv  input  1  latched GMII receive data valid
rx_er  input  1  latched GMII receive error
clear  input  1  synchronous clear of all statistics counters
d_out  output  8  forwarded data byte
strobe_out  output  1  d_out valid; contiguous per frame
frame_end  output  1  high with the last strobed byte of a frame
frame_bad  output  1  qualifies frame_end; frame was poisoned or truncated
frame_cnt  output  cnt_w  frames forwarded (good + bad)
err_cnt  output  cnt_w  frames poisoned by rx_er
trunc_cnt  output  cnt_w  frames truncated at max_len
fc_cnt  output  cnt_w  false-carrier episodes

Behaviour:
- Reset (async, rst_n=0): d_out=0, strobe_out=0, frame_end=0, frame_bad=0, all counters 0, pipeline cleared, state=RESYNC.
- Pipeline: two register stages; byte sampled with rx_dv=1 at edge n appears on d_out/strobe_out after edge n+2. The second stage lets the block know a byte is last before emitting it.
- States:
  - RESYNC: nothing forwarded; go to IDLE on the first cycle rx_dv=0. This handles reset released mid-frame; that frame is not counted.
  - IDLE: rx_dv=1 goes to FRAME. len=1, poison=0, and poison is set immediately if rx_er=1.
  - FRAME: every cycle with rx_dv=1 increments len; rx_dv&rx_er sets poison.
    - rx_dv=0 ends the frame: the previously accepted byte becomes last; go to IDLE.
    - When len reaches max_len, that byte is the last one; truncated=1; go to DROP.
  - DROP: input ignored; go to IDLE when rx_dv=0.
- Last byte of a frame:
  - frame_end=1 on the same cycle as the last byte's strobe_out.
  - frame_bad = poison | truncated.
  - If frame_bad, d_out = ~byte; otherwise the byte passes unmodified.
  - All non-last bytes always pass unmodified.
- Single-byte frame (rx_dv high one cycle): one strobe with frame_end=1.
- Back-to-back frames separated by a single rx_dv=0 cycle: both forwarded, with one idle cycle on strobe_out between them.
- rx_er with rx_dv=0:
  - rxd==8'h0E marks false carrier. fc_cnt increments once per contiguous episode, on its first cycle.
  - Any other rxd is ignored.
- Counter updates:
  - frame_cnt +1 on every frame_end.
  - err_cnt +1 on frame_end when poison=1.
  - trunc_cnt +1 on frame_end when truncated=1.
  - A frame both poisoned and truncated bumps both err_cnt and trunc_cnt.
- Counter rules: all counters saturate at all-ones. clear has priority over an increment in the same cycle, so the result is 0.
- Counters update one cycle after the corresponding frame_end or false-carrier event.
- len counter saturates and never wraps.

Test Plan:
- 64-byte frame (8 preamble/SFD + 56 bytes), no rx_er:
  - exact bytes out, 2-cycle latency, 64 contiguous strobes
  - frame_end on byte 64, frame_bad=0
  - frame_cnt=1, err_cnt=0
- Same frame with rx_er pulsed on byte 20:
  - bytes 1..63 unchanged, byte 64 inverted (e.g. 0x5A -> 0xA5)
  - frame_bad=1, err_cnt=1
- max_len=16, rx_dv held for 40 bytes:
  - 16 strobes, byte 16 inverted, frame_end/frame_bad=1
  - no output for bytes 17..40, trunc_cnt=1
  - next frame forwarded normally
- rx_dv=0, rx_er=1, rxd=0x0E for 3 cycles, then idle, then again for 1 cycle -> fc_cnt=2; no strobe_out.
- Reset released mid-frame (rx_dv high for 10 more cycles):
  - no strobes and no counter change for that frame
  - following frame forwarded normally
- Counter saturation/clear: preload via 65535 frames (or force cnt_w=4 with 16 frames):
  - count holds at all-ones
  - clear asserted concurrently with frame_end -> frame_cnt=0
